// File: rtl/video_pkg.sv
// rtl/video_pkg.sv - shared state type, 1080p60 defaults and coordinate width
package video_pkg;

  localparam int COORD_W = 12;

  localparam int DEF_HACT = 1920;
  localparam int DEF_HFP  = 88;
  localparam int DEF_HSW  = 44;
  localparam int DEF_HBP  = 148;
  localparam int DEF_VACT = 1080;
  localparam int DEF_VFP  = 4;
  localparam int DEF_VSW  = 5;
  localparam int DEF_VBP  = 36;

  typedef enum logic [1:0] {
    ST_ACTIVE = 2'd0,
    ST_FP     = 2'd1,
    ST_SYNC   = 2'd2,
    ST_BP     = 2'd3
  } axis_state_e;

endpackage

// File: rtl/vtg_axis.sv
// rtl/vtg_axis.sv - one timing axis: position counter, ACTIVE/FP/SYNC/BP FSM, wrap flag
module vtg_axis
  import video_pkg::*;
#(
  parameter int ACT = DEF_HACT,
  parameter int FP  = DEF_HFP,
  parameter int SW  = DEF_HSW,
  parameter int BP  = DEF_HBP
) (
  input  logic               clk_i,
  input  logic               rst_ni,
  input  logic               en_i,
  output logic [COORD_W-1:0] pos_o,
  output axis_state_e        state_o,
  output logic               wrap_o
);

  localparam int TOTAL = ACT + FP + SW + BP;
  localparam logic [COORD_W-1:0] POS_LAST = COORD_W'(TOTAL - 1);
  localparam logic [COORD_W-1:0] POS_FP   = COORD_W'(ACT);
  localparam logic [COORD_W-1:0] POS_SYNC = COORD_W'(ACT + FP);
  localparam logic [COORD_W-1:0] POS_BP   = COORD_W'(ACT + FP + SW);

  logic [COORD_W-1:0] pos_q, pos_d;
  axis_state_e        state_q, state_d;

  assign wrap_o = (pos_q == POS_LAST);

  // The state always describes pos_q, so it is chosen from the position being entered.
  always_comb begin
    pos_d   = wrap_o ? '0 : pos_q + 1'b1;
    state_d = state_q;
    if (pos_d == '0)            state_d = ST_ACTIVE;
    else if (pos_d == POS_FP)   state_d = ST_FP;
    else if (pos_d == POS_SYNC) state_d = ST_SYNC;
    else if (pos_d == POS_BP)   state_d = ST_BP;
  end

  always_ff @(posedge clk_i) begin
    if (!rst_ni) begin
      pos_q   <= '0;
      state_q <= ST_ACTIVE;
    end else if (en_i) begin
      pos_q   <= pos_d;
      state_q <= state_d;
    end
  end

  assign pos_o   = pos_q;
  assign state_o = state_q;

endmodule

// File: rtl/video_timing_gen.sv
// rtl/video_timing_gen.sv - raster timing generator with registered hs/vs/de, pixel coordinates and sof
module video_timing_gen
  import video_pkg::*;
#(
  parameter int HACT = DEF_HACT,
  parameter int HFP  = DEF_HFP,
  parameter int HSW  = DEF_HSW,
  parameter int HBP  = DEF_HBP,
  parameter int VACT = DEF_VACT,
  parameter int VFP  = DEF_VFP,
  parameter int VSW  = DEF_VSW,
  parameter int VBP  = DEF_VBP
) (
  input  logic               clk,
  input  logic               rst,
  input  logic               en,
  output logic               hs,
  output logic               vs,
  output logic               de,
  output logic [COORD_W-1:0] hcnt,
  output logic [COORD_W-1:0] vcnt,
  output logic               sof
);

  if (HACT < 1 || HFP < 1 || HSW < 1 || HBP < 1 ||
      VACT < 1 || VFP < 1 || VSW < 1 || VBP < 1) begin : g_bad_zero
    $error("video_timing_gen: every timing parameter must be >= 1");
  end
  if (HACT + HFP + HSW + HBP > 4096 ||
      VACT + VFP + VSW + VBP > 4096) begin : g_bad_total
    $error("video_timing_gen: HTOTAL and VTOTAL must not exceed 4096");
  end

  logic [COORD_W-1:0] hpos, vpos;
  axis_state_e        hstate, vstate;
  logic               h_wrap, v_wrap;

  vtg_axis #(.ACT(HACT), .FP(HFP), .SW(HSW), .BP(HBP)) u_haxis (
    .clk_i   (clk),
    .rst_ni  (rst),
    .en_i    (en),
    .pos_o   (hpos),
    .state_o (hstate),
    .wrap_o  (h_wrap)
  );

  vtg_axis #(.ACT(VACT), .FP(VFP), .SW(VSW), .BP(VBP)) u_vaxis (
    .clk_i   (clk),
    .rst_ni  (rst),
    .en_i    (en && h_wrap),
    .pos_o   (vpos),
    .state_o (vstate),
    .wrap_o  (v_wrap)
  );

  // Set while the counters sit on (0,0): after reset or after the last pixel of a frame.
  logic at_origin_q;

  logic               hs_q, vs_q, de_q, sof_q;
  logic [COORD_W-1:0] hcnt_q, vcnt_q;
  logic               hs_d, vs_d, de_d;
  logic [COORD_W-1:0] hcnt_d, vcnt_d;

  always_comb begin
    de_d   = (hstate == ST_ACTIVE) && (vstate == ST_ACTIVE);
    hs_d   = (hstate == ST_SYNC);
    vs_d   = (vstate == ST_SYNC);
    hcnt_d = de_d ? hpos : '0;
    vcnt_d = (vstate == ST_ACTIVE) ? vpos : '0;
  end

  always_ff @(posedge clk) begin
    if (!rst) begin
      at_origin_q <= 1'b1;
      hs_q        <= 1'b0;
      vs_q        <= 1'b0;
      de_q        <= 1'b0;
      hcnt_q      <= '0;
      vcnt_q      <= '0;
      sof_q       <= 1'b0;
    end else if (en) begin
      at_origin_q <= h_wrap && v_wrap;
      hs_q        <= hs_d;
      vs_q        <= vs_d;
      de_q        <= de_d;
      hcnt_q      <= hcnt_d;
      vcnt_q      <= vcnt_d;
      sof_q       <= at_origin_q;
    end else begin
      // Stalled: everything holds except sof, which must stay a single pulse.
      sof_q <= 1'b0;
    end
  end

  assign hs   = hs_q;
  assign vs   = vs_q;
  assign de   = de_q;
  assign hcnt = hcnt_q;
  assign vcnt = vcnt_q;
  assign sof  = sof_q;

endmodule

// File: tb/tb_video_timing_gen.sv
// tb/tb_video_timing_gen.sv - scoreboard bench for video_timing_gen with small raster parameters
module tb_video_timing_gen;

  localparam int HACT = 4, HFP = 1, HSW = 2, HBP = 1;
  localparam int VACT = 3, VFP = 1, VSW = 1, VBP = 1;
  localparam int HT = HACT + HFP + HSW + HBP;
  localparam int VT = VACT + VFP + VSW + VBP;

  logic        clk = 1'b0;
  logic        rst = 1'b0;
  logic        en  = 1'b0;
  logic        hs, vs, de, sof;
  logic [11:0] hcnt, vcnt;

  always #5 clk = ~clk;

  video_timing_gen #(
    .HACT(HACT), .HFP(HFP), .HSW(HSW), .HBP(HBP),
    .VACT(VACT), .VFP(VFP), .VSW(VSW), .VBP(VBP)
  ) dut (
    .clk  (clk),
    .rst  (rst),
    .en   (en),
    .hs   (hs),
    .vs   (vs),
    .de   (de),
    .hcnt (hcnt),
    .vcnt (vcnt),
    .sof  (sof)
  );

  typedef struct packed {
    logic        hs;
    logic        vs;
    logic        de;
    logic [11:0] hcnt;
    logic [11:0] vcnt;
    logic        sof;
  } out_t;

  out_t obs;
  assign obs = {hs, vs, de, hcnt, vcnt, sof};

  out_t sb_q[$];
  out_t last_exp;
  int   mx, my;
  int   errors = 0;
  int   checks = 0;

  function automatic out_t model_out(input int x, input int y);
    out_t o;
    o.hs   = (x >= HACT + HFP) && (x < HACT + HFP + HSW);
    o.vs   = (y >= VACT + VFP) && (y < VACT + VFP + VSW);
    o.de   = (x < HACT) && (y < VACT);
    o.hcnt = o.de ? 12'(x) : 12'd0;
    o.vcnt = (y < VACT) ? 12'(y) : 12'd0;
    o.sof  = (x == 0) && (y == 0);
    return o;
  endfunction

  task automatic cycle(input logic en_v, input logic rst_v, output out_t got);
    out_t e;
    en  = en_v;
    rst = rst_v;
    if (!rst_v) begin
      e  = '0;
      mx = 0;
      my = 0;
    end else if (en_v) begin
      e = model_out(mx, my);
      mx++;
      if (mx == HT) begin
        mx = 0;
        my = (my + 1) % VT;
      end
    end else begin
      e     = last_exp;
      e.sof = 1'b0;
    end
    last_exp = e;
    sb_q.push_back(e);
    @(posedge clk);
    #1;
    e = sb_q.pop_front();
    got = obs;
    checks++;
    if (got !== e) begin
      errors++;
      $display("FAIL sb t=%0t got hs=%b vs=%b de=%b hcnt=%0d vcnt=%0d sof=%b expected hs=%b vs=%b de=%b hcnt=%0d vcnt=%0d sof=%b",
               $time, got.hs, got.vs, got.de, got.hcnt, got.vcnt, got.sof,
               e.hs, e.vs, e.de, e.hcnt, e.vcnt, e.sof);
    end
  endtask

  task automatic test_reset();
    out_t g;
    for (int i = 0; i < 3; i++) cycle(1'b1, 1'b0, g);
    checks++;
    if (g !== out_t'(0)) begin
      errors++;
      $display("FAIL reset_state got %h expected 0", g);
    end
  endtask

  task automatic test_frame();
    out_t g;
    logic prev_hs = 1'b0, prev_vs = 1'b0, prev_de = 1'b0;
    int de_cnt = 0, sof_cnt = 0, hs_pulses = 0, vs_pulses = 0;
    int hs_run = 0, vs_run = 0, bad_hs_w = 0, bad_vs_w = 0;
    int px = 0, py = 0, pc_err = 0, pc_chk = 0;
    for (int i = 0; i < 2 * HT * VT; i++) begin
      cycle(1'b1, 1'b1, g);
      if (g.de) de_cnt++;
      if (g.sof) begin
        sof_cnt++;
        px = 0;
        py = 0;
      end
      if (g.hs) hs_run++;
      else if (prev_hs) begin
        hs_pulses++;
        if (hs_run != HSW) bad_hs_w++;
        hs_run = 0;
      end
      if (g.vs) vs_run++;
      else if (prev_vs) begin
        vs_pulses++;
        if (vs_run != VSW * HT) bad_vs_w++;
        vs_run = 0;
      end
      if (g.de) begin
        pc_chk++;
        if (g.hcnt !== 12'(px) || g.vcnt !== 12'(py)) pc_err++;
        px++;
      end else if (prev_de) begin
        px = 0;
        py++;
      end
      prev_hs = g.hs;
      prev_vs = g.vs;
      prev_de = g.de;
    end
    checks++;
    if (de_cnt != 2 * HACT * VACT) begin
      errors++; $display("FAIL de_count got %0d expected %0d", de_cnt, 2 * HACT * VACT);
    end
    checks++;
    if (sof_cnt != 2) begin
      errors++; $display("FAIL sof_count got %0d expected 2", sof_cnt);
    end
    checks++;
    if (hs_pulses != 2 * VT || bad_hs_w != 0) begin
      errors++; $display("FAIL hs_pulses got %0d (bad widths %0d) expected %0d", hs_pulses, bad_hs_w, 2 * VT);
    end
    checks++;
    if (vs_pulses != 2 || bad_vs_w != 0) begin
      errors++; $display("FAIL vs_pulses got %0d (bad widths %0d) expected 2", vs_pulses, bad_vs_w);
    end
    checks++;
    if (pc_err != 0 || pc_chk != 2 * HACT * VACT) begin
      errors++; $display("FAIL pixel_counter got %0d mismatches over %0d de cycles expected 0 over %0d", pc_err, pc_chk, 2 * HACT * VACT);
    end
  endtask

  task automatic test_stall();
    out_t g;
    logic pat [4] = '{1'b1, 1'b0, 1'b0, 1'b1};
    int enabled = 0, de_cnt = 0, sof_cnt = 0, k = 0;
    while (enabled < HT * VT && k < 1000) begin
      cycle(pat[k % 4], 1'b1, g);
      if (pat[k % 4]) begin
        enabled++;
        if (g.de) de_cnt++;
      end
      if (g.sof) sof_cnt++;
      k++;
    end
    checks++;
    if (de_cnt != HACT * VACT) begin
      errors++; $display("FAIL stall_de_count got %0d expected %0d", de_cnt, HACT * VACT);
    end
    checks++;
    if (sof_cnt != 1) begin
      errors++; $display("FAIL stall_sof_count got %0d expected 1", sof_cnt);
    end
  endtask

  task automatic test_reset_in_vsync();
    out_t g;
    int n = 0;
    while (!(my == VACT + VFP && mx == 3) && n < 200) begin
      cycle(1'b1, 1'b1, g);
      n++;
    end
    checks++;
    if (g.vs !== 1'b1) begin
      errors++; $display("FAIL pre_reset_vs got %b expected 1", g.vs);
    end
    cycle(1'b1, 1'b0, g);
    checks++;
    if (g.vs !== 1'b0) begin
      errors++; $display("FAIL reset_vs got %b expected 0", g.vs);
    end
    cycle(1'b1, 1'b1, g);
    checks++;
    if (g.sof !== 1'b1 || g.de !== 1'b1 || g.hcnt !== 12'd0 || g.vcnt !== 12'd0) begin
      errors++; $display("FAIL restart got sof=%b de=%b hcnt=%0d vcnt=%0d expected sof=1 de=1 hcnt=0 vcnt=0",
                         g.sof, g.de, g.hcnt, g.vcnt);
    end
    for (int i = 0; i < HT * VT; i++) cycle(1'b1, 1'b1, g);
  endtask

  initial begin
    mx = 0;
    my = 0;
    last_exp = '0;
    @(posedge clk);
    #1;
    test_reset();
    test_frame();
    test_stall();
    test_reset_in_vsync();
    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule
